// File: rtl/doodle_sprite_fetch.sv
// doodle_sprite_fetch: per-pixel sprite-ROM address generator for the doodle.
// Pose and position are latched once per frame (frame_clk rise) so the sprite
// never tears. The hit flag rides a pipeline that lines up with the ROM data.
// DrawX/DrawY to doodle_on/color_idx latency is ROM_LAT+2 Clk cycles.
//
// Optional feature macro: DOODLE_MIRROR_EN
//   undefined : 3 stored images (right=0, left=1, up=2), NIMG=3
//   defined   : 2 stored images (right=0, up=1); left = image 0 mirrored in X
//
// Ports:
//   Clk, Reset_n       system clock, async active-low reset
//   frame_clk          vsync-rate frame clock (asynchronous, synchronised here)
//   state              pose: 0=right, 1=left, 2=up, 3=right
//   DoodleX, DoodleY   sprite top-left corner in screen pixels
//   DrawX, DrawY       current beam position
//   rom_addr           sprite-ROM read address (registered)
//   rom_data           sprite-ROM data, ROM_LAT cycles after rom_addr
//   doodle_on          opaque sprite pixel at the aligned beam position
//   color_idx          palette index aligned with doodle_on (0 = transparent)
module doodle_sprite_fetch #(
  parameter int unsigned SPR_W   = 32,
  parameter int unsigned SPR_H   = 32,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned PIX_W   = 4,
`ifdef DOODLE_MIRROR_EN
  localparam int unsigned NIMG   = 2,
`else
  localparam int unsigned NIMG   = 3,
`endif
  localparam int unsigned ADDR_W = $clog2(NIMG * SPR_W * SPR_H)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [1:0]        state,
  input  logic [9:0]        DoodleX,
  input  logic [9:0]        DoodleY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              doodle_on,
  output logic [PIX_W-1:0]  color_idx
);

  localparam int unsigned XW    = $clog2(SPR_W);
  localparam int unsigned YW    = $clog2(SPR_H);
  localparam int unsigned IMG_W = ADDR_W - XW - YW;

  typedef enum logic [1:0] {
    POSE_RIGHT = 2'd0,
    POSE_LEFT  = 2'd1,
    POSE_UP    = 2'd2,
    POSE_ALT   = 2'd3
  } pose_e;

  logic        fclk_meta;
  logic        fclk_sync;
  logic        fclk_sync_d;
  logic        frame_rise;

  pose_e       shadow_pose;
  logic [9:0]  shadow_x;
  logic [9:0]  shadow_y;
  logic        frame_valid;

  logic [10:0]       dx;
  logic [10:0]       dy;
  logic              hit;
  logic [IMG_W-1:0]  img;
  logic [XW-1:0]     dx_eff;
  logic [ADDR_W-1:0] addr_next;

  logic [ROM_LAT:0]  hit_p;

  // frame_clk synchroniser and rising-edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fclk_meta   <= 1'b0;
      fclk_sync   <= 1'b0;
      fclk_sync_d <= 1'b0;
    end else begin
      fclk_meta   <= frame_clk;
      fclk_sync   <= fclk_meta;
      fclk_sync_d <= fclk_sync;
    end
  end

  assign frame_rise = fclk_sync & ~fclk_sync_d;

  // Once-per-frame shadow of pose and position
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_pose <= POSE_RIGHT;
      shadow_x    <= 10'd0;
      shadow_y    <= 10'd0;
      frame_valid <= 1'b0;
    end else if (frame_rise) begin
      shadow_pose <= pose_e'(state);
      shadow_x    <= DoodleX;
      shadow_y    <= DoodleY;
      frame_valid <= 1'b1;
    end
  end

  // Stage 0: 11-bit offsets; a negative offset has bit 10 set, so it can never
  // pass the range test and there is no wrap at the screen edges.
  assign dx  = {1'b0, DrawX} - {1'b0, shadow_x};
  assign dy  = {1'b0, DrawY} - {1'b0, shadow_y};
  assign hit = frame_valid
             & ~dx[10] & (dx < 11'(SPR_W))
             & ~dy[10] & (dy < 11'(SPR_H));

  // Image select and optional horizontal mirror for the left pose
  always_comb begin
    img    = '0;
    dx_eff = dx[XW-1:0];
    unique case (shadow_pose)
`ifdef DOODLE_MIRROR_EN
      POSE_LEFT: dx_eff = XW'(SPR_W - 1) - dx[XW-1:0];
      POSE_UP:   img    = IMG_W'(1);
`else
      POSE_LEFT: img    = IMG_W'(1);
      POSE_UP:   img    = IMG_W'(2);
`endif
      default:   img    = '0;
    endcase
  end

  // Power-of-two sprite sizes make img*W*H + dy*W + dx a plain concatenation
  assign addr_next = hit ? {img, dy[YW-1:0], dx_eff} : '0;

  // Stage 1 address register and hit pipeline aligned with ROM latency
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      hit_p    <= '0;
    end else begin
      rom_addr <= addr_next;
      hit_p    <= {hit_p[ROM_LAT-1:0], hit};
    end
  end

  // Output stage: registered one cycle after rom_data becomes valid
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      doodle_on <= 1'b0;
      color_idx <= '0;
    end else begin
      doodle_on <= hit_p[ROM_LAT] & (rom_data != '0);
      color_idx <= hit_p[ROM_LAT] ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_doodle_sprite_fetch.sv
// Bench for doodle_sprite_fetch: a frame-level behavioural model plus directed
// probes with hand-computed expectations.
module tb_doodle_sprite_fetch;

  localparam int unsigned SPR_W   = 32;
  localparam int unsigned SPR_H   = 32;
  localparam int unsigned ROM_LAT = 1;
  localparam int unsigned PIX_W   = 4;
`ifdef DOODLE_MIRROR_EN
  localparam int unsigned NIMG    = 2;
  localparam bit          MIRROR  = 1'b1;
`else
  localparam int unsigned NIMG    = 3;
  localparam bit          MIRROR  = 1'b0;
`endif
  localparam int unsigned ADDR_W  = $clog2(NIMG * SPR_W * SPR_H);
  localparam int          LAT     = ROM_LAT + 2;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_clk;
  logic [1:0]        state;
  logic [9:0]        DoodleX, DoodleY, DrawX, DrawY;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic              doodle_on;
  logic [PIX_W-1:0]  color_idx;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  doodle_sprite_fetch #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT), .PIX_W(PIX_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .state(state),
    .DoodleX(DoodleX), .DoodleY(DoodleY), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .doodle_on(doodle_on), .color_idx(color_idx)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM contents: address 0 holds 5, any address with low nibble 5 is transparent
  function automatic logic [PIX_W-1:0] rom_fn(input int a);
    return PIX_W'(a) ^ PIX_W'(5);
  endfunction

  // ROM with ROM_LAT cycles of read latency
  logic [PIX_W-1:0] rq [ROM_LAT];
  always @(posedge Clk) begin
    rq[0] <= rom_fn(int'(rom_addr));
    for (int i = 1; i < ROM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign rom_data = rq[ROM_LAT-1];

  function automatic int img_of(input int pose);
    if (MIRROR) return (pose == 2) ? 1 : 0;
    return (pose == 1) ? 1 : (pose == 2) ? 2 : 0;
  endfunction

  // Behavioural model: shadow taken on the third Clk edge that follows
  // frame_clk going high; outputs are the expected pixel delayed by LAT.
  int m_sx, m_sy, m_pose;
  bit m_valid;
  bit fh1, fh2, fh3;
  int exp_addr;
  bit exp_on  [LAT];
  int exp_col [LAT];

  always @(posedge Clk or negedge Reset_n) begin
    int dx, dy, a;
    bit h;
    if (!Reset_n) begin
      m_sx = 0; m_sy = 0; m_pose = 0; m_valid = 1'b0;
      fh1 = 1'b0; fh2 = 1'b0; fh3 = 1'b0;
      exp_addr = 0;
      for (int i = 0; i < LAT; i++) begin exp_on[i] = 1'b0; exp_col[i] = 0; end
    end else begin
      dx = int'(DrawX) - m_sx;
      dy = int'(DrawY) - m_sy;
      h  = m_valid && dx >= 0 && dx < int'(SPR_W) && dy >= 0 && dy < int'(SPR_H);
      a  = 0;
      if (h) begin
        if (MIRROR && m_pose == 1) dx = int'(SPR_W) - 1 - dx;
        a = img_of(m_pose) * int'(SPR_W * SPR_H) + dy * int'(SPR_W) + dx;
      end
      for (int i = LAT - 1; i > 0; i--) begin
        exp_on[i]  = exp_on[i-1];
        exp_col[i] = exp_col[i-1];
      end
      exp_col[0] = h ? int'(rom_fn(a)) : 0;
      exp_on[0]  = (exp_col[0] != 0);
      exp_addr   = a;
      if (fh2 && !fh3) begin
        m_sx = int'(DoodleX); m_sy = int'(DoodleY); m_pose = int'(state);
        m_valid = 1'b1;
      end
      fh3 = fh2; fh2 = fh1; fh1 = frame_clk;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    if (check_en) begin
      chk("model rom_addr",  int'(rom_addr),  exp_addr);
      chk("model doodle_on", int'(doodle_on), int'(exp_on[LAT-1]));
      chk("model color_idx", int'(color_idx), exp_col[LAT-1]);
    end
  end

  task automatic frame_pulse();
    @(posedge Clk); #2 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #2 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
  endtask

  task automatic set_doodle(input int x, input int y, input int st);
    @(posedge Clk); #2;
    DoodleX = 10'(x); DoodleY = 10'(y); state = 2'(st);
  endtask

  task automatic probe(input int x, input int y, input int ea,
                       input bit eon, input int ecol, input string nm);
    @(posedge Clk); #2;
    DrawX = 10'(x); DrawY = 10'(y);
    @(posedge Clk); @(negedge Clk);
    chk({nm, " rom_addr"}, int'(rom_addr), ea);
    repeat (ROM_LAT + 1) @(posedge Clk);
    @(negedge Clk);
    chk({nm, " doodle_on"}, int'(doodle_on), int'(eon));
    chk({nm, " color_idx"}, int'(color_idx), ecol);
  endtask

  // Expectation for a plain right-facing hit/miss sweep
  task automatic probe_right(input int x, input int y, input int ox, input int oy,
                             input string nm);
    int ea, ec;
    bit hh;
    hh = (x >= ox) && (x < ox + 32) && (y >= oy) && (y < oy + 32);
    ea = hh ? (x - ox) + 32 * (y - oy) : 0;
    ec = hh ? int'(rom_fn(ea)) : 0;
    probe(x, y, ea, ec != 0, ec, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea;
    Reset_n = 1'b1; frame_clk = 1'b0; state = 2'd0;
    DoodleX = 10'd0; DoodleY = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
    #1 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset rom_addr",  int'(rom_addr),  0);
    chk("reset doodle_on", int'(doodle_on), 0);
    chk("reset color_idx", int'(color_idx), 0);
    @(posedge Clk); #3 Reset_n = 1'b1;
    check_en = 1'b1;

    // Some activity, then reset mid-stream
    set_doodle(100, 100, 0);
    frame_pulse();
    probe(100, 100, 0, 1'b1, 5, "pre-reset hit");
    @(posedge Clk); #3 Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #3 Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("t1 no frame doodle_on", int'(doodle_on), 0);
      chk("t1 no frame color_idx", int'(color_idx), 0);
    end
    frame_pulse();
    probe(100, 100, 0, 1'b1, 5, "t1 first frame");

    // Sweep across the sprite row 10 at X=200
    set_doodle(200, 50, 0);
    frame_pulse();
    for (int x = 198; x <= 233; x++) probe_right(x, 60, 200, 50, "t2 sweep");

    // Pose / image select
    set_doodle(200, 50, 1);
    frame_pulse();
    ea = MIRROR ? 28 : 1027;
    probe(203, 50, ea, 1'b1, int'(rom_fn(ea)), "t3 left");
    set_doodle(200, 50, 2);
    frame_pulse();
    ea = MIRROR ? 1027 : 2051;
    probe(203, 50, ea, 1'b1, 6, "t3 up");
    set_doodle(200, 50, 3);
    frame_pulse();
    probe(203, 50, 3, 1'b1, 6, "t3 pose3");

    // Transparent pixel: address 5 holds 0
    set_doodle(200, 50, 0);
    frame_pulse();
    probe(205, 50, 5, 1'b0, 0, "t4 transparent");

    // Mid-frame position change is ignored until the next frame
    set_doodle(100, 100, 0);
    frame_pulse();
    set_doodle(300, 100, 0);
    probe(100, 100, 0, 1'b1, 5, "t5 old pos hit");
    probe(131, 100, 31, 1'b1, 10, "t5 old pos right edge");
    probe(300, 100, 0, 1'b0, 0, "t5 new pos before frame");
    frame_pulse();
    probe(300, 100, 0, 1'b1, 5, "t5 new pos hit");
    probe(331, 100, 31, 1'b1, 10, "t5 new pos right edge");
    probe(100, 100, 0, 1'b0, 0, "t5 old pos after frame");

    // Partly off-screen sprite: no wrap to the left edge
    set_doodle(620, 100, 0);
    frame_pulse();
    for (int x = 620; x <= 639; x++) probe_right(x, 105, 620, 100, "t6 edge");
    for (int x = 0; x <= 11; x++) probe(x, 105, 0, 1'b0, 0, "t6 no wrap");

    repeat (5) @(posedge Clk);
    @(negedge Clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
